alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

Issue controller that shares the integer ALU between two requesters (e.g. the integer pipe and the branch unit). It arbitrates round-robin, drives the ALU operand/opcode/start inputs, and holds them stable through multi-cycle MUL/DIV/REM operations. It captures result and flag into a response register with a valid/ready handshake. Illegal opcodes and a hung multi-cycle unit are reported as error responses.

## Interface
- TAG_W, 4, width of the requester-supplied tag echoed in the response
- TIMEOUT, 64, maximum cycles to wait for alu_valid after start; must be ≥ 2

- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- reqN_valid  input  1  request N (N=0,1) presents an operation
- reqN_ready  output  1  request N accepted this cycle
- reqN_a, reqN_b  input  32  operands for request N
- reqN_opcode  input  5  ALU opcode for request N (0x00–0x15 legal)
- reqN_tag  input  TAG_W  opaque tag for request N
- rsp_valid  output  1  response held valid
- rsp_ready  input  1  consumer accepts response
- rsp_id  output  1  requester index of the response
- rsp_tag  output  TAG_W  tag of the accepted request
- rsp_result  output  32  captured ALU result (0 on error)
- rsp_flag  output  1  captured ALU flag for compare opcodes 0x10–0x15, else 0
- rsp_err  output  1  1 = illegal opcode or timeout
- alu_a, alu_b  output  32  ALU operands
- alu_opcode  output  5  ALU opcode
- alu_start  output  1  one-cycle start pulse to ALU
- alu_result  input  32  ALU result
- alu_flag  input  1  ALU compare flag
- alu_valid  input  1  ALU result valid (combinational for single-cycle ops)
- busy  output  1  1 whenever state ≠ IDLE

## Operation
- FSM states: IDLE, EXEC, WAIT, RESP.
- IDLE
  - If any reqN_valid, grant one and assert its reqN_ready for exactly that cycle.
  - Latch a, b, opcode, tag, and id.
  - Legal opcode → EXEC. Opcode > 0x15 → RESP with rsp_err=1, result 0, flag 0, ALU not started.
- Arbitration
  - Round-robin on last_grant (reset value 1, so req0 wins the first contention).
  - If both requesters are valid, grant the one ≠ last_grant. If only one is valid, grant it.
  - last_grant updates on every grant.
- EXEC
  - alu_start=1 for this cycle only; alu_a/alu_b/alu_opcode driven from latches.
  - alu_valid=1 in the same cycle → capture result and flag → RESP.
  - Otherwise → WAIT, with the timeout counter cleared.
- WAIT
  - alu_start=0; operands and opcode held stable, because ALU output muxing is combinational on opcode.
  - Counter increments each cycle.
  - alu_valid=1 → capture → RESP.
  - Counter reaches TIMEOUT-1 without alu_valid → RESP with rsp_err=1, result 0, flag 0.
  - If alu_valid and timeout coincide, alu_valid wins (no error).
- RESP
  - rsp_valid=1; all rsp_* fields stable until rsp_valid && rsp_ready, then → IDLE.
  - No new request is accepted while in RESP.
- Flag capture: rsp_flag = alu_flag only for opcodes 0x10–0x15; 0 otherwise.
- alu_valid is ignored in IDLE and RESP (stale pulses after a timeout are discarded).
- alu_a, alu_b, and alu_opcode hold their last latched values outside EXEC/WAIT. The ALU is never started outside EXEC.

## Timing
- Reset: state=IDLE, last_grant=1, counter=0.
- All outputs are 0 during reset, including alu_a/b/opcode, reqN_ready, rsp_*, and busy.
- reqN_ready is combinational from reqN_valid in IDLE. All other outputs come from registers or the state decode.
- Single-cycle op, request accepted in cycle T:
  - alu_start in T+1.
  - rsp_valid from T+2.
  - Earliest next accept is the cycle after the rsp handshake.
- Multi-cycle op: rsp_valid is asserted the cycle after alu_valid is seen.
- Timeout: rsp_valid with err asserted TIMEOUT+1 cycles after the start cycle, at the latest.
- Illegal opcode: rsp_valid in T+1.
- rst mid-operation (any state) → immediate IDLE, pending response dropped. The ALU is reset by the same rst.

## Test plan
- Single ADD: req0 a=5, b=7, op 0x00, tag 3, rsp_ready=1 → one alu_start pulse at T+1; rsp_valid at T+2 with result 12, id 0, tag 3, err 0, flag 0.
- Contention: req0 and req1 both valid continuously with distinct tags → grants alternate 0,1,0,1 starting with 0; each rsp carries the matching id/tag.
- Multi-cycle DIV: op 0x06, a=-20, b=3, ALU model returns valid after 33 cycles → alu_opcode/a/b stable throughout WAIT, single start pulse, rsp result 0xFFFFFFFA (−6).
- Backpressure and compare: op 0x12 (signed less-than), a=-1, b=1, rsp_ready low for 5 cycles → rsp fields stable, flag 1, result 1; no reqN_ready asserted until the handshake.
- Errors:
  - Opcode 0x1F → err=1 at T+1, alu_start never asserted.
  - MUL with alu_valid held low, TIMEOUT=64 → err=1, result 0.
  - A subsequent late alu_valid is ignored.
- Reset mid-WAIT: assert rst during a DIV → busy=0, rsp_valid=0, last_grant=1 immediately; the next request completes normally.

Source files
------------

// File: rtl/alu_issue_ctrl_if.sv
// rtl/alu_issue_ctrl_if.sv - request, response and ALU-side signal bundle for alu_issue_ctrl
interface alu_issue_ctrl_if #(
  parameter int TAG_W = 4
);
  logic              req0_valid;
  logic              req0_ready;
  logic [31:0]       req0_a;
  logic [31:0]       req0_b;
  logic [4:0]        req0_opcode;
  logic [TAG_W-1:0]  req0_tag;

  logic              req1_valid;
  logic              req1_ready;
  logic [31:0]       req1_a;
  logic [31:0]       req1_b;
  logic [4:0]        req1_opcode;
  logic [TAG_W-1:0]  req1_tag;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [TAG_W-1:0]  rsp_tag;
  logic [31:0]       rsp_result;
  logic              rsp_flag;
  logic              rsp_err;

  logic [31:0]       alu_a;
  logic [31:0]       alu_b;
  logic [4:0]        alu_opcode;
  logic              alu_start;
  logic [31:0]       alu_result;
  logic              alu_flag;
  logic              alu_valid;

  // slave is the issue controller; master is the requesters, consumer and ALU
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_opcode, req0_tag,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_opcode, req1_tag,
    output req1_ready,
    output rsp_valid, rsp_id, rsp_tag, rsp_result, rsp_flag, rsp_err,
    input  rsp_ready,
    output alu_a, alu_b, alu_opcode, alu_start,
    input  alu_result, alu_flag, alu_valid
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_opcode, req0_tag,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_opcode, req1_tag,
    input  req1_ready,
    input  rsp_valid, rsp_id, rsp_tag, rsp_result, rsp_flag, rsp_err,
    output rsp_ready,
    input  alu_a, alu_b, alu_opcode, alu_start,
    output alu_result, alu_flag, alu_valid
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - round-robin issue of two requesters onto one shared integer ALU
module alu_issue_ctrl #(
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  alu_issue_ctrl_if.slave  bus,
  output logic             busy
);

  localparam int         CNT_W   = $clog2(TIMEOUT) + 1;
  localparam logic [4:0] OP_MAX  = 5'h15;
  localparam logic [4:0] CMP_LO  = 5'h10;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic              last_grant;
  logic [CNT_W-1:0]  cnt;

  logic [31:0]       lat_a;
  logic [31:0]       lat_b;
  logic [4:0]        lat_op;
  logic [TAG_W-1:0]  lat_tag;
  logic              lat_id;

  logic [31:0]       res_q;
  logic              flag_q;
  logic              err_q;

  logic              grant_any;
  logic              grant_id;
  logic [31:0]       sel_a;
  logic [31:0]       sel_b;
  logic [4:0]        sel_op;
  logic [TAG_W-1:0]  sel_tag;
  logic              sel_legal;
  logic              lat_is_cmp;

  logic              accept;
  logic              capture;
  logic              set_err;
  logic              cnt_clr;
  logic              cnt_inc;

  // Round-robin: on contention the requester that did not win last time goes next
  always_comb begin
    grant_any = bus.req0_valid | bus.req1_valid;
    grant_id  = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant_id = ~last_grant;
    end else begin
      grant_id = bus.req1_valid;
    end
  end

  always_comb begin
    sel_a     = grant_id ? bus.req1_a      : bus.req0_a;
    sel_b     = grant_id ? bus.req1_b      : bus.req0_b;
    sel_op    = grant_id ? bus.req1_opcode : bus.req0_opcode;
    sel_tag   = grant_id ? bus.req1_tag    : bus.req0_tag;
    sel_legal = (sel_op <= OP_MAX);
  end

  assign lat_is_cmp = (lat_op >= CMP_LO) && (lat_op <= OP_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    set_err   = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    unique case (state)
      IDLE: begin
        if (grant_any) begin
          accept    = 1'b1;
          set_err   = ~sel_legal;
          state_nxt = sel_legal ? EXEC : RESP;
        end
      end
      EXEC: begin
        if (bus.alu_valid) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end else begin
          cnt_clr   = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        // a result arriving on the last allowed cycle beats the timeout
        if (bus.alu_valid) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end else if (cnt == CNT_LAST) begin
          set_err   = 1'b1;
          state_nxt = RESP;
        end else begin
          cnt_inc   = 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
      cnt        <= '0;
      lat_a      <= '0;
      lat_b      <= '0;
      lat_op     <= '0;
      lat_tag    <= '0;
      lat_id     <= 1'b0;
      res_q      <= '0;
      flag_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (accept) begin
        last_grant <= grant_id;
        lat_a      <= sel_a;
        lat_b      <= sel_b;
        lat_op     <= sel_op;
        lat_tag    <= sel_tag;
        lat_id     <= grant_id;
      end
      if (cnt_clr) begin
        cnt <= '0;
      end else if (cnt_inc) begin
        cnt <= cnt + 1'b1;
      end
      if (capture) begin
        res_q  <= bus.alu_result;
        flag_q <= lat_is_cmp & bus.alu_flag;
        err_q  <= 1'b0;
      end else if (set_err) begin
        res_q  <= '0;
        flag_q <= 1'b0;
        err_q  <= 1'b1;
      end
    end
  end

  // ready is combinational but must read 0 while reset is held
  assign bus.req0_ready = accept & ~grant_id & ~rst;
  assign bus.req1_ready = accept &  grant_id & ~rst;

  assign bus.alu_a      = lat_a;
  assign bus.alu_b      = lat_b;
  assign bus.alu_opcode = lat_op;
  assign bus.alu_start  = (state == EXEC);

  assign bus.rsp_valid  = (state == RESP);
  assign bus.rsp_id     = lat_id;
  assign bus.rsp_tag    = lat_tag;
  assign bus.rsp_result = res_q;
  assign bus.rsp_flag   = flag_q;
  assign bus.rsp_err    = err_q;

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - directed scoreboard bench for alu_issue_ctrl with a latency-configurable ALU model
module tb_alu_issue_ctrl;
  localparam int TAG_W   = 4;
  localparam int TIMEOUT = 64;

  logic clk = 1'b0;
  logic rst;
  logic busy;

  alu_issue_ctrl_if #(.TAG_W(TAG_W)) bus ();

  alu_issue_ctrl #(.TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             id;
    logic [TAG_W-1:0] tag;
    logic [31:0]      result;
    logic             flag;
    logic             err;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_rsp    = 0;
  int   n_start  = 0;

  int   alu_lat    = 0;
  bit   alu_hang   = 1'b0;
  bit   late_valid = 1'b0;
  bit   pend;
  int   rem;

  function automatic logic [31:0] model_res(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      5'h00:   return a + b;
      5'h01:   return a - b;
      5'h05:   return a * b;
      5'h06:   return (b == 0) ? 32'hFFFF_FFFF : 32'($signed(a) / $signed(b));
      5'h07:   return (b == 0) ? a : 32'($signed(a) % $signed(b));
      5'h12:   return {31'd0, $signed(a) < $signed(b)};
      default: return a ^ b;
    endcase
  endfunction

  // ALU model; flag is deliberately 1 on non-compare ops so masking is visible
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= 1'b0;
      rem  <= 0;
    end else if (bus.alu_start && alu_lat > 0 && !alu_hang) begin
      pend <= 1'b1;
      rem  <= alu_lat;
    end else if (pend) begin
      rem <= rem - 1;
      if (rem == 1) pend <= 1'b0;
    end
  end

  assign bus.alu_result = model_res(bus.alu_opcode, bus.alu_a, bus.alu_b);
  assign bus.alu_flag   = (bus.alu_opcode == 5'h12) ? ($signed(bus.alu_a) < $signed(bus.alu_b)) : 1'b1;
  assign bus.alu_valid  = late_valid ||
                          (!alu_hang && ((bus.alu_start && alu_lat == 0) || (pend && rem == 1)));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.alu_start) n_start++;
    if (!rst && bus.rsp_valid && bus.rsp_ready) begin
      rsp_t e;
      n_rsp++;
      check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("rsp_id",     bus.rsp_id,     e.id);
        check("rsp_tag",    bus.rsp_tag,    e.tag);
        check("rsp_result", bus.rsp_result, e.result);
        check("rsp_flag",   bus.rsp_flag,   e.flag);
        check("rsp_err",    bus.rsp_err,    e.err);
      end
    end
  end

  task automatic wait_rsp(input string tag, input int budget, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.rsp_valid && cyc < budget);
    check(tag, bus.rsp_valid, 1'b1);
  endtask

  task automatic drv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cyc;
    int s0;
    int r0;
    bit ok;

    rst = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_a = '0; bus.req0_b = '0; bus.req0_opcode = '0; bus.req0_tag = '0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_opcode = '0; bus.req1_tag = '0;
    bus.rsp_ready  = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_busy",      busy,            1'b0);
    check("rst_rsp_valid", bus.rsp_valid,   1'b0);
    check("rst_ready0",    bus.req0_ready,  1'b0);
    check("rst_alu_start", bus.alu_start,   1'b0);
    check("rst_alu_a",     bus.alu_a,       32'd0);
    check("rst_alu_op",    bus.alu_opcode,  5'd0);
    drv();
    rst = 1'b0;

    // single-cycle ADD
    bus.req0_valid = 1'b1; bus.req0_a = 32'd5; bus.req0_b = 32'd7; bus.req0_opcode = 5'h00; bus.req0_tag = 4'd3;
    bus.rsp_ready  = 1'b1;
    exp_q.push_back('{id: 1'b0, tag: 4'd3, result: 32'd12, flag: 1'b0, err: 1'b0});
    @(negedge clk);
    check("add_ready0_T",  bus.req0_ready, 1'b1);
    check("add_ready1_T",  bus.req1_ready, 1'b0);
    check("add_start_T",   bus.alu_start,  1'b0);
    drv();
    bus.req0_valid = 1'b0;
    @(negedge clk);
    check("add_start_T1",  bus.alu_start,  1'b1);
    check("add_alu_a",     bus.alu_a,      32'd5);
    check("add_alu_b",     bus.alu_b,      32'd7);
    check("add_rsp_T1",    bus.rsp_valid,  1'b0);
    @(negedge clk);
    check("add_rsp_T2",    bus.rsp_valid,  1'b1);
    check("add_start_T2",  bus.alu_start,  1'b0);
    drv();

    // illegal opcode: error response one cycle after accept, ALU untouched
    s0 = n_start;
    bus.req1_valid = 1'b1; bus.req1_a = 32'd1; bus.req1_b = 32'd2; bus.req1_opcode = 5'h1F; bus.req1_tag = 4'd9;
    exp_q.push_back('{id: 1'b1, tag: 4'd9, result: 32'd0, flag: 1'b0, err: 1'b1});
    @(negedge clk);
    check("ill_ready1",    bus.req1_ready, 1'b1);
    drv();
    bus.req1_valid = 1'b0;
    @(negedge clk);
    check("ill_rsp_T1",    bus.rsp_valid,  1'b1);
    check("ill_err",       bus.rsp_err,    1'b1);
    check("ill_start",     bus.alu_start,  1'b0);
    drv();
    check("ill_no_start",  n_start - s0,   0);

    // 33-cycle signed DIV with operands held through WAIT
    alu_lat = 33;
    s0 = n_start;
    bus.req0_valid = 1'b1; bus.req0_a = 32'hFFFF_FFEC; bus.req0_b = 32'd3; bus.req0_opcode = 5'h06; bus.req0_tag = 4'd4;
    exp_q.push_back('{id: 1'b0, tag: 4'd4, result: 32'hFFFF_FFFA, flag: 1'b0, err: 1'b0});
    @(negedge clk);
    check("div_ready0",    bus.req0_ready, 1'b1);
    drv();
    bus.req0_valid = 1'b0;
    ok = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (!bus.rsp_valid)
        ok &= (bus.alu_a == 32'hFFFF_FFEC) && (bus.alu_b == 32'd3) && (bus.alu_opcode == 5'h06) && busy;
    end while (!bus.rsp_valid && cyc < 100);
    check("div_hold",      ok,             1'b1);
    check("div_latency",   cyc,            35);
    drv();
    check("div_one_start", n_start - s0,   1);
    alu_lat = 0;

    // signed compare under backpressure, competing request held off
    bus.rsp_ready  = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_a = 32'hFFFF_FFFF; bus.req1_b = 32'd1; bus.req1_opcode = 5'h12; bus.req1_tag = 4'd7;
    exp_q.push_back('{id: 1'b1, tag: 4'd7, result: 32'd1, flag: 1'b1, err: 1'b0});
    @(negedge clk);
    check("cmp_ready1",    bus.req1_ready, 1'b1);
    drv();
    bus.req1_valid = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_a = 32'd1; bus.req0_b = 32'd1; bus.req0_opcode = 5'h00; bus.req0_tag = 4'd2;
    @(negedge clk);
    check("cmp_exec_ready0", bus.req0_ready, 1'b0);
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      ok &= bus.rsp_valid && (bus.rsp_result == 32'd1) && bus.rsp_flag && !bus.rsp_err &&
            (bus.rsp_tag == 4'd7) && bus.rsp_id && !bus.req0_ready && !bus.req1_ready;
    end
    check("cmp_stall_stable", ok, 1'b1);
    drv();
    bus.rsp_ready = 1'b1;
    exp_q.push_back('{id: 1'b0, tag: 4'd2, result: 32'd2, flag: 1'b0, err: 1'b0});
    @(negedge clk);
    check("cmp_hs_ready0", bus.req0_ready, 1'b0);
    @(negedge clk);
    check("cmp_next_accept", bus.req0_ready, 1'b1);
    drv();
    bus.req0_valid = 1'b0;
    wait_rsp("add2_rsp", 20, cyc);
    drv();

    // MUL against a hung ALU times out, then a stale valid is ignored
    alu_hang = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_a = 32'd3; bus.req0_b = 32'd4; bus.req0_opcode = 5'h05; bus.req0_tag = 4'hC;
    exp_q.push_back('{id: 1'b0, tag: 4'hC, result: 32'd0, flag: 1'b0, err: 1'b1});
    @(negedge clk);
    check("to_ready0",     bus.req0_ready, 1'b1);
    drv();
    bus.req0_valid = 1'b0;
    @(negedge clk);
    check("to_start",      bus.alu_start,  1'b1);
    wait_rsp("to_rsp", 200, cyc);
    check("to_latency",    cyc,            TIMEOUT + 1);
    check("to_err",        bus.rsp_err,    1'b1);
    drv();
    r0 = n_rsp;
    alu_hang   = 1'b0;
    late_valid = 1'b1;
    @(negedge clk);
    check("late_busy",     busy,           1'b0);
    check("late_rsp",      bus.rsp_valid,  1'b0);
    drv();
    late_valid = 1'b0;
    @(negedge clk);
    check("late_busy2",    busy,           1'b0);
    check("late_no_rsp",   n_rsp - r0,     0);
    drv();

    // reset asserted while a DIV is waiting
    alu_lat = 33;
    bus.req1_valid = 1'b1; bus.req1_a = 32'd100; bus.req1_b = 32'd7; bus.req1_opcode = 5'h06; bus.req1_tag = 4'd1;
    @(negedge clk);
    check("rw_ready1",     bus.req1_ready, 1'b1);
    drv();
    bus.req1_valid = 1'b0;
    repeat (5) drv();
    check("rw_busy_pre",   busy,           1'b1);
    rst = 1'b1;
    #1;
    check("rw_busy",       busy,           1'b0);
    check("rw_rsp_valid",  bus.rsp_valid,  1'b0);
    check("rw_alu_start",  bus.alu_start,  1'b0);
    check("rw_alu_a",      bus.alu_a,      32'd0);
    repeat (2) drv();
    rst = 1'b0;
    alu_lat = 0;

    // contention right after reset: grants alternate starting with req0
    bus.req0_valid = 1'b1; bus.req0_a = 32'd100; bus.req0_b = 32'd1; bus.req0_opcode = 5'h00; bus.req0_tag = 4'hA;
    bus.req1_valid = 1'b1; bus.req1_a = 32'd200; bus.req1_b = 32'd2; bus.req1_opcode = 5'h00; bus.req1_tag = 4'h5;
    for (int g = 0; g < 4; g++) begin
      if (g % 2 == 0) exp_q.push_back('{id: 1'b0, tag: 4'hA, result: 32'd101, flag: 1'b0, err: 1'b0});
      else            exp_q.push_back('{id: 1'b1, tag: 4'h5, result: 32'd202, flag: 1'b0, err: 1'b0});
    end
    for (int g = 0; g < 4; g++) begin
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (!(bus.req0_ready || bus.req1_ready) && cyc < 20);
      check("cont_grant", {bus.req0_ready, bus.req1_ready}, (g % 2 == 0) ? 2'b10 : 2'b01);
    end
    drv();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    repeat (6) @(negedge clk);

    check("sb_drained",    exp_q.size(),   0);
    check("rsp_total",     n_rsp,          10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
